// File: rtl/game_player.sv
// game_player: autonomous script player for the game FSM.
// Replays a programmed script of 2-bit moves onto the game's dir input. It
// restarts the game through game_reset on any win, loss or error and keeps
// per-outcome counters for the session.
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_start            begin a session (sampled in IDLE/DONE only)
//   i_prog_we/addr/data script write port (ignored while busy)
//   i_num_moves        session length, clamped to DEPTH
//   o_dir, o_game_reset registered drive to the game
//   i_result           game status: 00 playing, 01 win, 10 loss, 11 error
//   o_busy, o_done     session status
//   o_wins, o_losses, o_errors  saturating outcome counters
module game_player #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CW         = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_prog_we,
  input  logic [$clog2(DEPTH)-1:0]   i_prog_addr,
  input  logic [1:0]                 i_prog_data,
  input  logic [$clog2(DEPTH):0]     i_num_moves,
  output logic [1:0]                 o_dir,
  output logic                       o_game_reset,
  input  logic [1:0]                 i_result,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CW-1:0]              o_wins,
  output logic [CW-1:0]              o_losses,
  output logic [CW-1:0]              o_errors
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]  CMAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRST,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } state_t;

  logic [1:0]     r_mem [DEPTH];

  state_t         r_state, w_state_nx;
  logic [PW-1:0]  r_ptr, w_ptr_nx;
  logic [PW-1:0]  r_num, w_num_nx;
  logic [RCW-1:0] r_rst_cnt, w_rst_cnt_nx;
  logic [1:0]     r_dir, w_dir_nx;
  logic           r_game_reset, w_game_reset_nx;
  logic           r_busy, w_busy_nx;
  logic           r_done, w_done_nx;
  logic [CW-1:0]  r_wins, w_wins_nx;
  logic [CW-1:0]  r_losses, w_losses_nx;
  logic [CW-1:0]  r_errors, w_errors_nx;

  logic [PW-1:0]  w_ptr_inc;
  logic [PW-1:0]  w_num_clamp;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // Script memory; frozen while a session is running
  always_ff @(posedge i_clk) begin
    if (i_prog_we && !r_busy) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_num        <= '0;
      r_rst_cnt    <= '0;
      r_dir        <= 2'b00;
      r_game_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wins       <= '0;
      r_losses     <= '0;
      r_errors     <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_ptr        <= w_ptr_nx;
      r_num        <= w_num_nx;
      r_rst_cnt    <= w_rst_cnt_nx;
      r_dir        <= w_dir_nx;
      r_game_reset <= w_game_reset_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_wins       <= w_wins_nx;
      r_losses     <= w_losses_nx;
      r_errors     <= w_errors_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_num_nx     = r_num;
    w_rst_cnt_nx = r_rst_cnt;
    w_dir_nx     = r_dir;
    w_wins_nx    = r_wins;
    w_losses_nx  = r_losses;
    w_errors_nx  = r_errors;
    w_ptr_inc    = r_ptr + PW'(1);
    w_num_clamp  = (i_num_moves > DEPTH_P) ? DEPTH_P : i_num_moves;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_num_nx     = w_num_clamp;
          w_ptr_nx     = '0;
          w_rst_cnt_nx = '0;
          w_wins_nx    = '0;
          w_losses_nx  = '0;
          w_errors_nx  = '0;
          w_state_nx   = (w_num_clamp == '0) ? S_DONE : S_GRST;
        end
      end
      S_GRST: begin
        if (r_rst_cnt == RC_LAST) begin
          w_state_nx = S_PLAY;
          w_dir_nx   = r_mem[r_ptr[AW-1:0]];
        end else begin
          w_rst_cnt_nx = r_rst_cnt + RCW'(1);
        end
      end
      S_PLAY: begin
        if (i_result == 2'b00) begin
          w_ptr_nx = w_ptr_inc;
          if (w_ptr_inc == r_num) begin
            w_state_nx = S_DRAIN;
          end else begin
            w_dir_nx = r_mem[w_ptr_inc[AW-1:0]];
          end
        end else begin
          // ptr stays put: the restart discards the move on dir, so it replays
          w_state_nx   = S_GRST;
          w_rst_cnt_nx = '0;
        end
      end
      S_DRAIN: begin
        w_state_nx = S_DONE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Outcome counting for any nonzero result seen while playing or draining
    if (r_state == S_PLAY || r_state == S_DRAIN) begin
      case (i_result)
        2'b01:   w_wins_nx   = sat_inc(r_wins);
        2'b10:   w_losses_nx = sat_inc(r_losses);
        2'b11:   w_errors_nx = sat_inc(r_errors);
        default: ;
      endcase
    end

    w_game_reset_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_GRST) ||
                      (w_state_nx == S_DONE);
    w_busy_nx       = (w_state_nx == S_GRST) || (w_state_nx == S_PLAY) ||
                      (w_state_nx == S_DRAIN);
    w_done_nx       = (w_state_nx == S_DONE);
  end

  assign o_dir        = r_dir;
  assign o_game_reset = r_game_reset;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_wins       = r_wins;
  assign o_losses     = r_losses;
  assign o_errors     = r_errors;

endmodule
